// File: rtl/reg_pipe_pkg.sv
`default_nettype none
// reg_pipe_pkg: shared helpers for the reg_pipe elastic pipeline.
// REG_PIPE_PARITY_EN sets PARITY_W to 1, which adds a parity bit to each stage.
package reg_pipe_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

`ifdef REG_PIPE_PARITY_EN
    localparam int PARITY_W = 1;
`else
    localparam int PARITY_W = 0;
`endif

endpackage
`default_nettype wire

// File: rtl/reg_pipe_stage.sv
`default_nettype none
// reg_pipe_stage: one data+valid register of the elastic pipe.
// Flush has priority over load. Data only updates when valid data arrives.
module reg_pipe_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         i_flush,
    input  logic         i_enable,
    input  logic         i_load,
    input  logic         i_src_valid,
    input  logic [W-1:0] i_src_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_enable && i_load) begin
            r_valid <= i_src_valid;
            if (i_src_valid) begin
                r_data <= i_src_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/reg_pipe.sv
`default_nettype none
// reg_pipe: elastic DEPTH-stage valid/ready pipeline with bubble collapsing and occupancy count.
// Defining REG_PIPE_PARITY_EN adds per-stage even parity and a sticky parity_err output.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             enable,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef REG_PIPE_PARITY_EN
    output logic             parity_err,
`endif
    output logic [CNT_W-1:0] occupancy
);

    localparam int SW = WIDTH + PARITY_W;

    logic [SW-1:0]    w_in_word;
    logic [SW-1:0]    w_d [DEPTH];
    logic [DEPTH-1:0] w_v;
    logic [DEPTH:0]   w_rdy;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CNT_W-1:0] r_occ;

`ifdef REG_PIPE_PARITY_EN
    assign w_in_word = {^in_data, in_data};
`else
    assign w_in_word = in_data;
`endif

    // Ready ripples from the output back: an empty stage accepts even when downstream stalls.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = enable & (~w_v[i] | w_rdy[i+1]);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic          w_src_valid;
        logic [SW-1:0] w_src_data;

        if (gi == 0) begin : g_head
            assign w_src_valid = in_valid;
            assign w_src_data  = w_in_word;
        end else begin : g_body
            assign w_src_valid = w_v[gi-1];
            assign w_src_data  = w_d[gi-1];
        end

        reg_pipe_stage #(
            .W (SW)
        ) u_stage (
            .clk         (clk),
            .clear_n     (clear_n),
            .i_flush     (flush),
            .i_enable    (enable),
            .i_load      (w_rdy[gi]),
            .i_src_valid (w_src_valid),
            .i_src_data  (w_src_data),
            .o_valid     (w_v[gi]),
            .o_data      (w_d[gi])
        );
    end

    assign in_ready  = w_rdy[0] & ~flush & clear_n;
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1][WIDTH-1:0];

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready & enable;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer && (r_occ != CNT_W'(DEPTH))) begin
            r_occ <= r_occ + CNT_W'(1);
        end else if (!w_in_xfer && w_out_xfer && (r_occ != '0)) begin
            r_occ <= r_occ - CNT_W'(1);
        end
    end

    assign occupancy = r_occ;

`ifdef REG_PIPE_PARITY_EN
    logic w_par_mismatch;
    logic r_parity_err;

    assign w_par_mismatch = (^out_data) != w_d[DEPTH-1][WIDTH];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_parity_err <= 1'b0;
        end else if (flush) begin
            r_parity_err <= 1'b0;
        end else if (out_valid && w_par_mismatch) begin
            r_parity_err <= 1'b1;
        end
    end

    assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe.sv
`default_nettype none
// tb_reg_pipe: directed scoreboard bench for reg_pipe (WIDTH=16, DEPTH=3).
module tb_reg_pipe;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3;
    localparam int CNT_W = 2;

    logic             clk       = 1'b0;
    logic             clear_n   = 1'b0;
    logic             enable    = 1'b1;
    logic             flush     = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CNT_W-1:0] occupancy;
`ifdef REG_PIPE_PARITY_EN
    logic             parity_err;
`endif

    reg_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .enable     (enable),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef REG_PIPE_PARITY_EN
        .parity_err (parity_err),
`endif
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;
    } exp_t;

    exp_t sbq[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   out_count = 0;
    bit   chk_lat   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: every counted output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (clear_n && out_valid && out_ready && enable) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=0x%0h required=none", out_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_data", {16'h0, out_data}, {16'h0, e.d});
                if (chk_lat) check("sb_latency", cyc - e.t, DEPTH);
                out_count++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int max_wait);
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back('{d, cyc});
                break;
            end
            if (k >= max_wait) begin
                check("send_accept", 0, 1);
                break;
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", sbq.size(), 0);
        step();
    endtask

    initial begin
        int idx;

        // Reset state
        in_valid = 1'b1;
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
        in_valid = 1'b0;
        step();
        step();
        clear_n = 1'b1;
        step();

        // Streaming at full rate
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send(16'(i), 0);
            if (i >= 3) check("stream_occ", occupancy, 3);
        end
        drain(10);
        check("stream_occ_end", occupancy, 0);
        check("stream_ovalid_end", out_valid, 0);
        chk_lat = 1'b0;

        // Back-pressure: only DEPTH words fit
        out_ready = 1'b0;
        idx       = 0;
        in_valid  = 1'b1;
        in_data   = 16'hA000;
        repeat (6) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back('{in_data, cyc});
                idx++;
            end
            step();
            in_data = 16'hA000 + 16'(idx);
        end
        check("bp_accepted", idx, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_occ", occupancy, 3);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_hold", out_data, 16'hA000);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_passthru", in_ready, 1);
        if (in_ready) sbq.push_back('{in_data, cyc});
        step();
        send(16'hA004, 2);
        drain(10);

        // Bubble collapse
        out_ready = 1'b0;
        send(16'h1111, 0);
        step();
        send(16'h2222, 0);
        step();
        step();
        check("bub_occ", occupancy, 2);
        out_ready = 1'b1;
        @(negedge clk);
        check("bub_first", {out_valid, out_data}, {1'b1, 16'h1111});
        @(negedge clk);
        check("bub_second", {out_valid, out_data}, {1'b1, 16'h2222});
        step();
        drain(4);

        // Flush discards contents and the word offered alongside it
        out_ready = 1'b0;
        send(16'hC001, 0);
        send(16'hC002, 0);
        check("fl_occ_pre", occupancy, 2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        @(negedge clk);
        check("fl_in_ready", in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        check("fl_occ", occupancy, 0);
        check("fl_out_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (4) step();
        check("fl_no_beef", {out_valid, occupancy}, 0);

        // Enable low freezes everything
        out_ready = 1'b0;
        send(16'hD001, 0);
        send(16'hD002, 0);
        step();
        step();
        enable    = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hD003;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("en_in_ready", in_ready, 0);
            check("en_state", {out_valid, out_data, 2'(occupancy)}, {1'b1, 16'hD001, 2'd2});
        end
        step();
        in_valid = 1'b0;
        enable   = 1'b1;
        drain(6);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(16'hE001, 0);
        send(16'hE002, 0);
        send(16'hE003, 0);
        check("rs_occ_pre", occupancy, 3);
        @(negedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        check("rs_out_valid", out_valid, 0);
        check("rs_out_data", out_data, 0);
        check("rs_occ", occupancy, 0);
        sbq.delete();
        step();
        clear_n   = 1'b1;
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        send(16'hF001, 0);
        drain(6);
        chk_lat = 1'b0;

`ifdef REG_PIPE_PARITY_EN
        check("par_init", parity_err, 0);
        out_ready = 1'b0;
        send(16'h00FF, 0);
        step();
        u_dut.g_stage[1].u_stage.r_data[0] = ~u_dut.g_stage[1].u_stage.r_data[0];
        step();
        step();
        check("par_err_set", parity_err, 1);
        step();
        check("par_err_sticky", parity_err, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        sbq.delete();
        check("par_err_clr", parity_err, 0);
`endif

        check("out_count", out_count, 15);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
